seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 37 +++
 rtl/seq_divider.sv | 194 +++++++++++++++++++
 tb/tb_seq_divider.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if
// Handshake and result bundle for the sequential restoring divider.
//   start       : request a division (honoured only while the divider is idle)
//   signed_mode : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   dividend    : WIDTH-bit dividend (sampled with start)
//   divisor     : WIDTH-bit divisor (sampled with start)
//   busy        : operation in flight
//   done        : one-cycle pulse, result fields valid
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : last accepted operation had a zero divisor
//   overflow    : last accepted operation was signed most-negative / -1
// master = requester side, slave = divider side.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
// Sequential restoring divider, one quotient bit per clock, with optional
// signed (truncate-toward-zero) mode, divide-by-zero and overflow flags.
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : seq_divider_if.slave (start/operands in, busy/done/results out)
// Normal latency: done is sampled high WIDTH+2 edges after the start edge;
// a zero divisor skips the iteration phase (2 edges).
module seq_divider #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r, next_state_s;
    logic [WIDTH:0]   a_r;          // partial remainder, one extra bit for the borrow
    logic [WIDTH-1:0] q_r;          // quotient under construction / raw dividend on /0
    logic [WIDTH-1:0] m_r;          // divisor magnitude
    logic [CW-1:0]    cnt_r;
    logic             q_neg_r, r_neg_r, dbz_pend_r, ov_pend_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_r, ov_r, busy_r, done_r;
    logic             busy_nx_s, done_nx_s;

    // Operand decode at acceptance time.
    logic             eff_signed_s, dvd_neg_s, dvs_neg_s, dvs_zero_s, ov_cond_s;
    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;

    assign eff_signed_s = SIGNED_EN & bus.signed_mode;
    assign dvd_neg_s    = eff_signed_s & bus.dividend[WIDTH-1];
    assign dvs_neg_s    = eff_signed_s & bus.divisor[WIDTH-1];
    // Most-negative negates to itself, which is the correct unsigned magnitude.
    assign dvd_mag_s    = dvd_neg_s ? (-bus.dividend) : bus.dividend;
    assign dvs_mag_s    = dvs_neg_s ? (-bus.divisor) : bus.divisor;
    assign dvs_zero_s   = (bus.divisor == {WIDTH{1'b0}});
    assign ov_cond_s    = eff_signed_s & (bus.dividend == MOST_NEG) & (bus.divisor == ALL_ONES);

    // One restoring step: shift {A,Q} left, then try A - M one bit wider so
    // the sign of the difference is the borrow.
    logic [WIDTH+1:0] shift_s, trial_s;
    logic             trial_ok_s;

    assign shift_s    = {a_r, q_r[WIDTH-1]};
    assign trial_s    = shift_s - {2'b00, m_r};
    assign trial_ok_s = ~trial_s[WIDTH+1];

    // Sign fix-up of the final magnitudes.
    logic [WIDTH-1:0] q_fix_s, r_fix_s;

    assign q_fix_s = q_neg_r ? (-q_r) : q_r;
    assign r_fix_s = r_neg_r ? (-a_r[WIDTH-1:0]) : a_r[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = dvs_zero_s ? FIX : CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(1)) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so busy/done can be registered.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (next_state_s)
            IDLE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
            CALC, FIX: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            DONE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath, result registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            m_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dbz_pend_r  <= 1'b0;
            ov_pend_r   <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            ov_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r        <= {(WIDTH+1){1'b0}};
                        // On /0 keep the raw dividend: it becomes the remainder as-is.
                        q_r        <= dvs_zero_s ? bus.dividend : dvd_mag_s;
                        m_r        <= dvs_mag_s;
                        cnt_r      <= CW'(WIDTH);
                        q_neg_r    <= dvd_neg_s ^ dvs_neg_s;
                        r_neg_r    <= dvd_neg_s;
                        dbz_pend_r <= dvs_zero_s;
                        ov_pend_r  <= ov_cond_s;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (trial_ok_s) begin
                        a_r <= trial_s[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        a_r <= shift_s[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (dbz_pend_r) begin
                        quotient_r  <= ALL_ONES;
                        remainder_r <= q_r;
                    end else begin
                        quotient_r  <= q_fix_s;
                        remainder_r <= r_fix_s;
                    end
                    dbz_r <= dbz_pend_r;
                    ov_r  <= ov_pend_r;
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ov_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Directed checks of seq_divider (WIDTH=8, SIGNED_EN=1) with hand-computed
// expected values. Latency is the number of rising edges from the start edge
// to the edge that samples done high.
module tb_seq_divider;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division from an idle divider and check the full result.
    task automatic run_div(input string tag, input logic sm, input logic [7:0] dvd,
                           input logic [7:0] dvs, input logic [7:0] exp_q,
                           input logic [7:0] exp_r, input logic exp_dbz,
                           input logic exp_ov, input int exp_lat);
        int n;
        bit seen;
        bus.signed_mode = sm;
        bus.dividend    = dvd;
        bus.divisor     = dvs;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq({tag, " busy"}, 32'(bus.busy), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        check_eq({tag, " latency"}, seen ? 32'(n + 1) : 32'hFFFF_FFFF, 32'(exp_lat));
        check_eq({tag, " quotient"}, 32'(bus.quotient), 32'(exp_q));
        check_eq({tag, " remainder"}, 32'(bus.remainder), 32'(exp_r));
        check_eq({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        check_eq({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ov));
        tick();
        check_eq({tag, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        int n;
        logic [7:0] q_seen, r_seen;

        tests_run    = 0;
        tests_failed = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.dividend    = 8'd0;
        bus.divisor     = 8'd0;
        repeat (2) tick();
        reset = 1'b0;

        check_eq("rst busy", 32'(bus.busy), 32'd0);
        check_eq("rst done", 32'(bus.done), 32'd0);
        check_eq("rst quotient", 32'(bus.quotient), 32'd0);
        check_eq("rst remainder", 32'(bus.remainder), 32'd0);
        check_eq("rst dbz", 32'(bus.div_by_zero), 32'd0);
        check_eq("rst ovf", 32'(bus.overflow), 32'd0);

        run_div("u100/7",   1'b0, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10);
        run_div("s-100/7",  1'b1, 8'h9C,  8'h07,  8'hF2, 8'hFE, 1'b0, 1'b0, 10);
        run_div("s100/-7",  1'b1, 8'h64,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10);
        run_div("u200/0",   1'b0, 8'd200, 8'd0,   8'hFF, 8'hC8, 1'b1, 1'b0, 2);
        run_div("u9/3",     1'b0, 8'd9,   8'd3,   8'h03, 8'h00, 1'b0, 1'b0, 10);
        run_div("s80/FF",   1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 10);
        run_div("u80/FF",   1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, 10);
        run_div("s-7/0",    1'b1, 8'hF9,  8'h00,  8'hFF, 8'hF9, 1'b1, 1'b0, 2);

        // A second start during CALC must not disturb the running 100/7.
        bus.signed_mode = 1'b0;
        bus.dividend    = 8'd100;
        bus.divisor     = 8'd7;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        dones  = 0;
        q_seen = 8'd0;
        r_seen = 8'd0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dones++;
                q_seen = bus.quotient;
                r_seen = bus.remainder;
            end
            tick();
        end
        check_eq("repulse done count", 32'(dones), 32'd1);
        check_eq("repulse quotient", 32'(q_seen), 32'h0E);
        check_eq("repulse remainder", 32'(r_seen), 32'h02);

        // A start presented while done is high is ignored.
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check_eq("9/3 done seen", 32'(bus.done), 32'd1);
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("start in DONE busy", 32'(bus.busy), 32'd0);
        tick();
        check_eq("start in DONE busy+1", 32'(bus.busy), 32'd0);
        check_eq("start in DONE quotient", 32'(bus.quotient), 32'h03);

        // Reset during CALC aborts with no done pulse and clears the outputs.
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort busy", 32'(bus.busy), 32'd0);
        check_eq("abort quotient", 32'(bus.quotient), 32'd0);
        check_eq("abort remainder", 32'(bus.remainder), 32'd0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done || bus.busy) dones++;
            tick();
        end
        check_eq("abort no activity", 32'(dones), 32'd0);
        run_div("u9/2", 1'b0, 8'd9, 8'd2, 8'h04, 8'h01, 1'b0, 1'b0, 10);

        // Start coinciding with reset is discarded.
        bus.start = 1'b1;
        reset     = 1'b1;
        tick();
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        check_eq("start with reset busy", 32'(bus.busy), 32'd0);
        check_eq("start with reset done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
